// File: rtl/ncl_pkg.sv
// Shared NCL definitions: bridge FSM states, dual-rail encodings and
// width-parameterized completion / NULL / illegal-code detection helpers.
package ncl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  // Rail pair order is {rail_t, rail_f}
  localparam logic [1:0] NCL_NULL = 2'b00;
  localparam logic [1:0] NCL_D0   = 2'b01;
  localparam logic [1:0] NCL_D1   = 2'b10;

  localparam int NCL_MAXW = 64;

  function automatic logic ncl_all_data(input logic [NCL_MAXW-1:0] t,
                                        input logic [NCL_MAXW-1:0] f,
                                        input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NCL_MAXW; i++)
      ok = ok & ((i >= w) || ({t[i], f[i]} == NCL_D0) || ({t[i], f[i]} == NCL_D1));
    return ok;
  endfunction

  function automatic logic ncl_all_null(input logic [NCL_MAXW-1:0] t,
                                        input logic [NCL_MAXW-1:0] f,
                                        input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NCL_MAXW; i++)
      ok = ok & ((i >= w) || ({t[i], f[i]} == NCL_NULL));
    return ok;
  endfunction

  function automatic logic ncl_any_illegal(input logic [NCL_MAXW-1:0] t,
                                           input logic [NCL_MAXW-1:0] f,
                                           input int w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NCL_MAXW; i++)
      bad = bad | ((i < w) && t[i] && f[i]);
    return bad;
  endfunction

endpackage

// File: rtl/ncl_sync_detect.sv
// Synchronizes a W-bit dual-rail vector into clk and reports its decoded
// value (true rail), the false rail, and whole-vector DATA/NULL/illegal flags.
module ncl_sync_detect
  import ncl_pkg::*;
#(
  parameter int W           = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_t,
  input  logic [W-1:0] in_f,
  output logic [W-1:0] value,
  output logic [W-1:0] rail_f,
  output logic         all_data,
  output logic         all_null,
  output logic         illegal
);

  logic [2*W-1:0] chain [SYNC_STAGES];

  // Multi-flop synchronizer chain for both rails of every bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= {in_t, in_f};
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign {value, rail_f} = chain[SYNC_STAGES-1];

  assign all_data = ncl_all_data(NCL_MAXW'(value), NCL_MAXW'(rail_f), W);
  assign all_null = ncl_all_null(NCL_MAXW'(value), NCL_MAXW'(rail_f), W);
  assign illegal  = ncl_any_illegal(NCL_MAXW'(value), NCL_MAXW'(rail_f), W);

endmodule

// File: rtl/ncl_mem_bridge.sv
// NCL dual-rail RW/address/data token to single-cycle synchronous memory access,
// with four-phase ack upstream and dual-rail read data downstream.
// Optional sticky illegal-code flag: define NCL_BRIDGE_ERR_EN.
module ncl_mem_bridge
  import ncl_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rw_t,
  input  logic          rw_f,
  input  logic [AW-1:0] addr_t,
  input  logic [AW-1:0] addr_f,
  input  logic [DW-1:0] wdata_t,
  input  logic [DW-1:0] wdata_f,
  output logic          ack_out,
  output logic [DW-1:0] rdata_t,
  output logic [DW-1:0] rdata_f,
  input  logic          rd_ack_in,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  localparam int W  = 1 + AW + DW;
  localparam int HW = 1 + AW;

  state_t state, state_nxt;
  logic [W-1:0] sync_t, sync_f, lat_t, lat_f;
  logic all_data, all_null, illegal;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic rd_ack, head_data, complete, match, is_write;
  logic load_lat, issue, capture, null_rdata, clr_ack;

  ncl_sync_detect #(.W(W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_t     ({rw_t, addr_t, wdata_t}),
    .in_f     ({rw_f, addr_f, wdata_f}),
    .value    (sync_t),
    .rail_f   (sync_f),
    .all_data (all_data),
    .all_null (all_null),
    .illegal  (illegal)
  );

  // Next-stage acknowledge synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], rd_ack_in};
  end

  assign rd_ack = ack_sync[SYNC_STAGES-1];

  // Reads only need rw+addr complete; a write also needs every wdata bit
  assign head_data = ncl_all_data(NCL_MAXW'(sync_t[W-1:DW]), NCL_MAXW'(sync_f[W-1:DW]), HW);
  assign complete  = head_data && (!sync_t[W-1] || all_data) && !illegal;
  assign match     = complete && (sync_t == lat_t) && (sync_f == lat_f);
  assign is_write  = lat_t[W-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (complete) state_nxt = SETTLE; else state_nxt = IDLE;
      SETTLE:  if (match) state_nxt = ACCESS; else state_nxt = SETTLE;
      ACCESS:  if (mem_ready) state_nxt = HOLD; else state_nxt = ACCESS;
      HOLD: begin
        if (is_write) begin
          if (all_null) state_nxt = IDLE; else state_nxt = HOLD;
        end else if (all_null && rd_ack) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = HOLD;
        end
      end
      DRAIN:   if (!rd_ack) state_nxt = IDLE; else state_nxt = DRAIN;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    load_lat   = 1'b0;
    issue      = 1'b0;
    capture    = 1'b0;
    null_rdata = 1'b0;
    clr_ack    = 1'b0;
    case (state)
      IDLE:   load_lat = complete;
      SETTLE: begin
        issue    = match;
        load_lat = !match;
      end
      ACCESS: capture = mem_ready;
      HOLD: begin
        if (is_write) clr_ack = all_null;
        else          null_rdata = all_null && rd_ack;
      end
      DRAIN:  clr_ack = !rd_ack;
      default: begin
        load_lat = 1'b0;
      end
    endcase
  end

  // Token latch and registered memory / handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_t     <= '0;
      lat_f     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack_out   <= 1'b0;
      rdata_t   <= '0;
      rdata_f   <= '0;
    end else begin
      mem_req <= issue;
      if (load_lat) begin
        lat_t <= sync_t;
        lat_f <= sync_f;
      end
      if (issue) begin
        mem_we    <= lat_t[W-1];
        mem_addr  <= lat_t[W-2:DW];
        mem_wdata <= lat_t[DW-1:0];
      end
      if (capture) begin
        ack_out <= 1'b1;
        if (!is_write) begin
          rdata_t <= mem_rdata;
          rdata_f <= ~mem_rdata;
        end
      end else if (clr_ack) begin
        ack_out <= 1'b0;
      end
      if (null_rdata) begin
        rdata_t <= '0;
        rdata_f <= '0;
      end
    end
  end

`ifdef NCL_BRIDGE_ERR_EN
  // Sticky flag for any synchronized 11 code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err | illegal;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_mem_bridge.sv
// Directed self-checking bench for ncl_mem_bridge (AW = DW = 8, SYNC_STAGES = 2).
module tb_ncl_mem_bridge;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rw_t = 1'b0, rw_f = 1'b0;
  logic [AW-1:0] addr_t = 8'h00, addr_f = 8'h00;
  logic [DW-1:0] wdata_t = 8'h00, wdata_f = 8'h00;
  logic          ack_out;
  logic [DW-1:0] rdata_t, rdata_f;
  logic          rd_ack_in = 1'b0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 8'h00;
  logic          mem_ready = 1'b0;
  logic          err;

  int compared = 0;
  int mismatched = 0;
  int req_cnt = 0;
  int base = 0;
  logic exp_err;

  ncl_mem_bridge #(.AW(AW), .DW(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rw_t(rw_t), .rw_f(rw_f),
    .addr_t(addr_t), .addr_f(addr_f), .wdata_t(wdata_t), .wdata_f(wdata_f),
    .ack_out(ack_out), .rdata_t(rdata_t), .rdata_f(rdata_f), .rd_ack_in(rd_ack_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_req === 1'b1) req_cnt++;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_null();
    rw_t = 1'b0; rw_f = 1'b0;
    addr_t = 8'h00; addr_f = 8'h00;
    wdata_t = 8'h00; wdata_f = 8'h00;
  endtask

  task automatic drive_read(input logic [7:0] a);
    rw_t = 1'b0; rw_f = 1'b1;
    addr_t = a; addr_f = ~a;
    wdata_t = 8'h00; wdata_f = 8'h00;
  endtask

  // Starts at the negedge where mem_req was just seen high for a read token
  task automatic read_tail(input string tag, input logic [7:0] d, input int order);
    step(1);
    chk1({tag, "_req_pulse_end"}, mem_req, 1'b0);
    step(1);
    mem_ready = 1'b1; mem_rdata = d;
    chk1({tag, "_ack_before_ready"}, ack_out, 1'b0);
    step(1);
    mem_ready = 1'b0; mem_rdata = 8'h00;
    chk8({tag, "_rdata_t"}, rdata_t, d);
    chk8({tag, "_rdata_f"}, rdata_f, ~d);
    chk1({tag, "_ack_set"}, ack_out, 1'b1);
    if (order == 0) begin
      rd_ack_in = 1'b1;
      step(4);
      chk8({tag, "_hold_wait_null"}, rdata_t, d);
      drive_null();
    end else if (order == 1) begin
      drive_null();
      step(4);
      chk8({tag, "_hold_wait_rdack"}, rdata_t, d);
      rd_ack_in = 1'b1;
    end else begin
      drive_null();
      rd_ack_in = 1'b1;
    end
    step(2);
    chk8({tag, "_rdata_before_null"}, rdata_t, d);
    step(1);
    chk8({tag, "_rdata_t_null"}, rdata_t, 8'h00);
    chk8({tag, "_rdata_f_null"}, rdata_f, 8'h00);
    chk1({tag, "_ack_in_drain"}, ack_out, 1'b1);
    rd_ack_in = 1'b0;
    step(2);
    chk1({tag, "_ack_before_drop"}, ack_out, 1'b1);
    step(1);
    chk1({tag, "_ack_dropped"}, ack_out, 1'b0);
  endtask

  task automatic full_read(input string tag, input logic [7:0] a, input logic [7:0] d,
                           input int order);
    base = req_cnt;
    drive_read(a);
    step(3);
    chki({tag, "_no_early_req"}, req_cnt - base, 0);
    step(1);
    chk1({tag, "_req"}, mem_req, 1'b1);
    chk1({tag, "_we"}, mem_we, 1'b0);
    chk8({tag, "_addr"}, mem_addr, a);
    read_tail(tag, d, order);
    step(2);
    chki({tag, "_one_access"}, req_cnt - base, 1);
  endtask

  initial begin
`ifdef NCL_BRIDGE_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_ack", ack_out, 1'b0);
    chk8("rst_rdata_t", rdata_t, 8'h00);
    chk8("rst_rdata_f", rdata_f, 8'h00);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk8("rst_addr", mem_addr, 8'h00);
    chk8("rst_wdata", mem_wdata, 8'h00);
    chk1("rst_err", err, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Basic read, NULL and rd_ack together
    full_read("rd", 8'h3C, 8'hA5, 2);

    // Write with mem_ready held high
    base = req_cnt;
    mem_ready = 1'b1;
    rw_t = 1'b1; rw_f = 1'b0;
    addr_t = 8'h10; addr_f = 8'hEF;
    wdata_t = 8'h7E; wdata_f = 8'h81;
    step(3);
    chki("wr_no_early_req", req_cnt - base, 0);
    step(1);
    chk1("wr_req", mem_req, 1'b1);
    chk1("wr_we", mem_we, 1'b1);
    chk8("wr_addr", mem_addr, 8'h10);
    chk8("wr_wdata", mem_wdata, 8'h7E);
    step(1);
    chk1("wr_req_pulse_end", mem_req, 1'b0);
    chk1("wr_ack_set", ack_out, 1'b1);
    chk8("wr_rdata_t_null", rdata_t, 8'h00);
    chk8("wr_rdata_f_null", rdata_f, 8'h00);
    drive_null();
    step(2);
    chk1("wr_ack_before_drop", ack_out, 1'b1);
    step(1);
    chk1("wr_ack_dropped", ack_out, 1'b0);
    step(3);
    chki("wr_one_access", req_cnt - base, 1);
    mem_ready = 1'b0;

    // Skewed arrival: address bits resolve one per cycle toward 0x96
    base = req_cnt;
    rw_t = 1'b0; rw_f = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr_t[i] = (i == 1 || i == 2 || i == 4 || i == 7);
      addr_f[i] = !(i == 1 || i == 2 || i == 4 || i == 7);
      if (i < 7) step(1);
    end
    chki("skew_no_req_partial", req_cnt - base, 0);
    step(3);
    chki("skew_no_early_req", req_cnt - base, 0);
    step(1);
    chk1("skew_req", mem_req, 1'b1);
    chk8("skew_addr", mem_addr, 8'h96);
    read_tail("skew", 8'h0F, 2);
    step(2);
    chki("skew_one_access", req_cnt - base, 1);

    // Handshake order variations
    full_read("ack_first", 8'h21, 8'hC3, 0);
    full_read("null_first", 8'h42, 8'h18, 1);

    // Reset while the access is outstanding
    base = req_cnt;
    drive_read(8'h55);
    step(4);
    chk1("rstmid_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rstmid_req_drop", mem_req, 1'b0);
    chk8("rstmid_addr", mem_addr, 8'h00);
    chk1("rstmid_ack", ack_out, 1'b0);
    chk8("rstmid_rdata_t", rdata_t, 8'h00);
    drive_null();
    step(2);
    rst_n = 1'b1;
    step(3);
    full_read("post_rst", 8'hC3, 8'h3C, 2);

    // Illegal 11 code on addr bit 3
    base = req_cnt;
    rw_t = 1'b0; rw_f = 1'b1;
    addr_t = 8'h3C; addr_f = 8'hCB;
    step(2);
    chk1("ill_err_early", err, 1'b0);
    step(1);
    chk1("ill_err", err, exp_err);
    step(6);
    chki("ill_no_req", req_cnt - base, 0);
    chk1("ill_err_sticky", err, exp_err);
    drive_null();
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
